pdes_sim_ctrl: RTL and testbench

//  Parametrised PDES simulation controller: sequences start/init/run/finish, injects initial events,

---
 rtl/pdes_sim_ctrl_pkg.sv | 26 ++
 rtl/pdes_sim_ctrl_gvt.sv | 51 +++++
 rtl/pdes_sim_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pdes_sim_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdes_sim_ctrl_pkg.sv
// Shared types for the PDES simulation controller: FSM states and the
// finish status codes reported to the host on rtn_status.
package pdes_sim_ctrl_pkg;

    // Controller phases.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT     = 3'd1,
        ST_READY    = 3'd2,
        ST_RUNNING  = 3'd3,
        ST_FINISHED = 3'd4
    } state_t;

    // Reason the last run ended.
    typedef enum logic [1:0] {
        RTN_DONE    = 2'd0,
        RTN_ABORT   = 2'd1,
        RTN_STARVED = 2'd2
    } rtn_status_t;

    // Width of the initial-event counter (NUM_INIT is at most 2**16-1).
    localparam int unsigned INIT_CNT_WID   = 16;
    // Width of the starvation counter.
    localparam int unsigned STARVE_CNT_WID = 32;

endpackage

// File: rtl/pdes_sim_ctrl_gvt.sv
// GVT unit: takes the minimum of the active-core time and the queue head
// time, keeps gvt monotonic and flags any candidate that would move it back.
module pdes_gvt_unit #(
    parameter int unsigned TIME_WID = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                update_en,
    input  logic [TIME_WID-1:0] min_time,
    input  logic                min_time_vld,
    input  logic [TIME_WID-1:0] head_time,
    input  logic                head_vld,
    output logic [TIME_WID-1:0] gvt,
    output logic                gvt_err
);

    logic [TIME_WID-1:0] cand;
    logic                cand_vld;

    // Candidate is the smaller of whichever time sources are valid.
    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        if (min_time_vld && head_vld) begin
            cand_vld = 1'b1;
            cand     = (min_time < head_time) ? min_time : head_time;
        end else if (min_time_vld) begin
            cand_vld = 1'b1;
            cand     = min_time;
        end else if (head_vld) begin
            cand_vld = 1'b1;
            cand     = head_time;
        end
    end

    // gvt only advances; a smaller candidate holds gvt and sets the sticky error.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            gvt     <= '0;
            gvt_err <= 1'b0;
        end else if (update_en && cand_vld) begin
            if (cand < gvt) begin
                gvt_err <= 1'b1;
            end else begin
                gvt <= cand;
            end
        end
    end

endmodule

// File: rtl/pdes_sim_ctrl.sv
// PDES simulation controller: sequences a run, injects the initial events,
// arbitrates enqueue of core results against dispatch to idle cores, and
// ends the run on end time, abort or starvation.
module pdes_sim_ctrl
    import pdes_sim_ctrl_pkg::*;
#(
    parameter int unsigned TIME_WID     = 16,
    parameter int unsigned NB_LPID      = 5,
    parameter int unsigned MSG_WID      = 32,
    parameter int unsigned NUM_INIT     = 16,
    parameter int unsigned SIMUL_ENQDEQ = 0,
    parameter int unsigned STARVE_CYC   = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [TIME_WID-1:0] end_time,
    input  logic                rcv_vld,
    input  logic [MSG_WID-1:0]  rcv_msg,
    output logic                rcv_ack,
    input  logic                core_avail,
    output logic                disp_vld,
    input  logic                q_full,
    input  logic                q_empty,
    input  logic [MSG_WID-1:0]  q_head,
    output logic                q_enq,
    output logic                q_deq,
    output logic [MSG_WID-1:0]  q_inp,
    input  logic [TIME_WID-1:0] min_time,
    input  logic                min_time_vld,
    output logic [TIME_WID-1:0] gvt,
    output logic                rtn_vld,
    output logic [1:0]          rtn_status,
    output logic                gvt_err,
    output logic                busy
);

    localparam int unsigned CANCEL_BIT = TIME_WID + NB_LPID;
    localparam logic [INIT_CNT_WID-1:0]   INIT_LAST  = INIT_CNT_WID'(NUM_INIT - 1);
    localparam logic [STARVE_CNT_WID-1:0] STARVE_LIM = STARVE_CNT_WID'(STARVE_CYC);

    state_t                    state_q, state_d;
    rtn_status_t               rtn_status_q, fin_status;
    logic                      fin_set;
    logic [INIT_CNT_WID-1:0]   init_cnt_q;
    logic [STARVE_CNT_WID-1:0] starve_cnt_q;
    logic [TIME_WID-1:0]       end_time_q;
    logic [MSG_WID-1:0]        init_msg;
    logic                      init_accept;
    logic                      run_start;
    logic                      rcv_is_null;
    logic                      starve_cond;
    logic                      starved;
    logic                      unused_q_head;

    // Only the timestamp of the queue head feeds the GVT.
    assign unused_q_head = ^q_head[MSG_WID-1:TIME_WID];

    assign run_start   = (state_q == ST_IDLE) && start;
    assign init_accept = (state_q == ST_INIT) && !q_full;
    assign rcv_is_null = rcv_msg[CANCEL_BIT]
                         && (rcv_msg[TIME_WID +: NB_LPID] == '0)
                         && (rcv_msg[TIME_WID-1:0] == '0);
    assign starve_cond = q_empty && !min_time_vld && !rcv_vld;
    assign starved     = (STARVE_CYC != 0) && (starve_cnt_q == STARVE_LIM);

    // Initial event: cancel=0, lp from the injection counter, time 0.
    always_comb begin
        init_msg = '0;
        init_msg[TIME_WID +: NB_LPID] = init_cnt_q[NB_LPID-1:0];
    end

    // Next-state logic; abort takes priority over any normal finish.
    always_comb begin
        state_d    = state_q;
        fin_status = RTN_DONE;
        fin_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_INIT;
            end
            ST_INIT: begin
                if (abort) begin
                    state_d = ST_FINISHED; fin_status = RTN_ABORT; fin_set = 1'b1;
                end else if (init_accept && (init_cnt_q == INIT_LAST)) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (abort) begin
                    state_d = ST_FINISHED; fin_status = RTN_ABORT; fin_set = 1'b1;
                end else begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (abort) begin
                    state_d = ST_FINISHED; fin_status = RTN_ABORT; fin_set = 1'b1;
                end else if (gvt > end_time_q) begin
                    state_d = ST_FINISHED; fin_status = RTN_DONE; fin_set = 1'b1;
                end else if (starved) begin
                    state_d = ST_FINISHED; fin_status = RTN_STARVED; fin_set = 1'b1;
                end
            end
            ST_FINISHED: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Queue strobes; reset squashes them in the same cycle it is asserted.
    always_comb begin
        rcv_ack = 1'b0;
        q_enq   = 1'b0;
        q_deq   = 1'b0;
        if (!reset) begin
            if (state_q == ST_INIT) begin
                q_enq = !q_full;
            end else if (state_q == ST_RUNNING) begin
                rcv_ack = rcv_vld && !q_full;
                q_enq   = rcv_ack && !rcv_is_null;
                if (SIMUL_ENQDEQ != 0) q_deq = !q_empty && core_avail;
                else                   q_deq = !rcv_ack && !q_empty && core_avail;
            end
        end
    end

    assign disp_vld   = q_deq;
    assign q_inp      = (state_q == ST_INIT) ? init_msg : rcv_msg;
    assign rtn_vld    = (state_q == ST_FINISHED);
    assign rtn_status = rtn_status_q;
    assign busy       = (state_q != ST_IDLE);

    // State, run parameters, counters and finish status.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            init_cnt_q   <= '0;
            starve_cnt_q <= '0;
            end_time_q   <= '0;
            rtn_status_q <= RTN_DONE;
        end else begin
            state_q <= state_d;
            if (run_start) begin
                end_time_q   <= end_time;
                init_cnt_q   <= '0;
                rtn_status_q <= RTN_DONE;
            end else if (init_accept) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
            if ((state_q == ST_RUNNING) && starve_cond) begin
                if (starve_cnt_q != STARVE_LIM) starve_cnt_q <= starve_cnt_q + 1'b1;
            end else begin
                starve_cnt_q <= '0;
            end
            if (fin_set) rtn_status_q <= fin_status;
        end
    end

    pdes_gvt_unit #(
        .TIME_WID (TIME_WID)
    ) u_gvt (
        .clk          (clk),
        .reset        (reset),
        .clear        (run_start),
        .update_en    (state_q == ST_RUNNING),
        .min_time     (min_time),
        .min_time_vld (min_time_vld),
        .head_time    (q_head[TIME_WID-1:0]),
        .head_vld     (!q_empty),
        .gvt          (gvt),
        .gvt_err      (gvt_err)
    );

endmodule

// File: tb/tb_pdes_sim_ctrl.sv
// Testbench for pdes_sim_ctrl: directed stimulus with a scoreboard that
// checks every enqueued message and every finish report in order.
module tb_pdes_sim_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [15:0] end_time;
    logic        rcv_vld;
    logic [31:0] rcv_msg;
    logic        core_avail, q_full, q_empty;
    logic [31:0] q_head;
    logic [15:0] min_time;
    logic        min_time_vld;

    logic        rcv_ack0, disp_vld0, q_enq0, q_deq0, rtn_vld0, gvt_err0, busy0;
    logic [31:0] q_inp0;
    logic [15:0] gvt0;
    logic [1:0]  rtn_status0;
    logic        rcv_ack1, disp_vld1, q_enq1, q_deq1, rtn_vld1, gvt_err1, busy1;
    logic [31:0] q_inp1;
    logic [15:0] gvt1;
    logic [1:0]  rtn_status1;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_enq[$];
    logic [1:0]  exp_rtn[$];
    logic [31:0] mon_e;
    logic [1:0]  mon_s;
    int          cyc;

    always #5 clk = ~clk;

    pdes_sim_ctrl #(
        .TIME_WID(16), .NB_LPID(5), .MSG_WID(32), .NUM_INIT(16),
        .SIMUL_ENQDEQ(0), .STARVE_CYC(8)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .end_time(end_time),
        .rcv_vld(rcv_vld), .rcv_msg(rcv_msg), .rcv_ack(rcv_ack0),
        .core_avail(core_avail), .disp_vld(disp_vld0),
        .q_full(q_full), .q_empty(q_empty), .q_head(q_head),
        .q_enq(q_enq0), .q_deq(q_deq0), .q_inp(q_inp0),
        .min_time(min_time), .min_time_vld(min_time_vld),
        .gvt(gvt0), .rtn_vld(rtn_vld0), .rtn_status(rtn_status0),
        .gvt_err(gvt_err0), .busy(busy0)
    );

    pdes_sim_ctrl #(
        .TIME_WID(16), .NB_LPID(5), .MSG_WID(32), .NUM_INIT(16),
        .SIMUL_ENQDEQ(1), .STARVE_CYC(8)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .end_time(end_time),
        .rcv_vld(rcv_vld), .rcv_msg(rcv_msg), .rcv_ack(rcv_ack1),
        .core_avail(core_avail), .disp_vld(disp_vld1),
        .q_full(q_full), .q_empty(q_empty), .q_head(q_head),
        .q_enq(q_enq1), .q_deq(q_deq1), .q_inp(q_inp1),
        .min_time(min_time), .min_time_vld(min_time_vld),
        .gvt(gvt1), .rtn_vld(rtn_vld1), .rtn_status(rtn_status1),
        .gvt_err(gvt_err1), .busy(busy1)
    );

    function automatic logic [31:0] mk(input logic cancel, input logic [4:0] lp, input logic [15:0] t);
        mk = {10'b0, cancel, lp, t};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every enqueue and every finish pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (q_enq0) begin
            total++;
            if (exp_enq.size() == 0) begin
                bad++;
                $display("FAIL enq_unexpected: got q_inp=%0h, required no enqueue", q_inp0);
            end else begin
                mon_e = exp_enq.pop_front();
                if (q_inp0 !== mon_e) begin
                    bad++;
                    $display("FAIL enq_data: got %0h, required %0h", q_inp0, mon_e);
                end
            end
        end
        if (rtn_vld0) begin
            total++;
            if (exp_rtn.size() == 0) begin
                bad++;
                $display("FAIL rtn_unexpected: got status=%0d, required no finish", rtn_status0);
            end else begin
                mon_s = exp_rtn.pop_front();
                if (rtn_status0 !== mon_s) begin
                    bad++;
                    $display("FAIL rtn_status: got %0d, required %0d", rtn_status0, mon_s);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; end_time = '0;
        rcv_vld = 1'b0; rcv_msg = '0; core_avail = 1'b0; q_full = 1'b0;
        q_empty = 1'b1; q_head = '0; min_time = '0; min_time_vld = 1'b0;

        // Reset state
        repeat (3) tick;
        @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_gvt", gvt0, 0);
        chk("rst_rtn_vld", rtn_vld0, 0);
        chk("rst_status", rtn_status0, 0);
        chk("rst_gvt_err", gvt_err0, 0);
        chk("rst_enq", q_enq0, 0);
        tick;
        reset = 1'b0;

        // Normal init: 16 injections, READY, first RUNNING cycle accepts rcv
        min_time_vld = 1'b1; min_time = 16'd0; end_time = 16'd1000;
        rcv_vld = 1'b1; rcv_msg = mk(1'b0, 5'd7, 16'd50);
        for (int i = 0; i < 16; i++) exp_enq.push_back(mk(1'b0, 5'(i), 16'd0));
        exp_enq.push_back(mk(1'b0, 5'd7, 16'd50));
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            chk("init_enq", q_enq0, (i < 16) || (i == 17));
            chk("init_ack", rcv_ack0, i == 17);
            tick;
        end
        rcv_vld = 1'b0;
        chk("init_all_seen", exp_enq.size(), 0);

        // Arbitration: rcv, core and queue head all present
        q_empty = 1'b0; q_head = mk(1'b0, 5'd2, 16'd5); core_avail = 1'b1;
        rcv_vld = 1'b1; rcv_msg = mk(1'b0, 5'd9, 16'd60);
        exp_enq.push_back(mk(1'b0, 5'd9, 16'd60));
        @(negedge clk);
        chk("arb0_enq", q_enq0, 1);
        chk("arb0_deq", q_deq0, 0);
        chk("arb1_enq", q_enq1, 1);
        chk("arb1_deq", q_deq1, 1);
        chk("arb1_disp", disp_vld1, 1);
        tick;
        q_full = 1'b1;
        @(negedge clk);
        chk("full_ack", rcv_ack0, 0);
        chk("full_enq", q_enq0, 0);
        chk("full_deq", q_deq0, 1);
        chk("full_disp", disp_vld0, 1);
        chk("full1_deq", q_deq1, 1);

        // Null message dropped, cancel with nonzero lp enqueued
        tick;
        q_full = 1'b0; q_empty = 1'b1; core_avail = 1'b0; rcv_msg = mk(1'b1, 5'd0, 16'd0);
        @(negedge clk);
        chk("null_ack", rcv_ack0, 1);
        chk("null_enq", q_enq0, 0);
        tick;
        rcv_msg = mk(1'b1, 5'd3, 16'd0);
        exp_enq.push_back(mk(1'b1, 5'd3, 16'd0));
        @(negedge clk);
        chk("cancel_ack", rcv_ack0, 1);
        chk("cancel_enq", q_enq0, 1);

        // Abort while RUNNING
        tick;
        rcv_vld = 1'b0; abort = 1'b1;
        exp_rtn.push_back(2'd1);
        tick;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_run_rtn", rtn_vld0, 1);
        tick;
        @(negedge clk);
        chk("abort_run_pulse", rtn_vld0, 0);
        chk("abort_run_idle", busy0, 0);
        chk("abort_run_hold", rtn_status0, 1);

        // End-time finish and GVT monotonic check
        tick;
        end_time = 16'd100; min_time = 16'd90; min_time_vld = 1'b1;
        for (int i = 0; i < 16; i++) exp_enq.push_back(mk(1'b0, 5'(i), 16'd0));
        exp_rtn.push_back(2'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        @(negedge clk);
        chk("start_clr_status", rtn_status0, 0);
        repeat (19) tick;
        @(negedge clk);
        chk("gvt_90", gvt0, 90);
        tick;
        min_time = 16'd101;
        @(negedge clk);
        chk("gvt_lat", gvt0, 90);
        tick;
        min_time = 16'd95;
        @(negedge clk);
        chk("gvt_101", gvt0, 101);
        chk("gvt_err_pre", gvt_err0, 0);
        chk("fin_not_yet", rtn_vld0, 0);
        tick;
        @(negedge clk);
        chk("fin_rtn", rtn_vld0, 1);
        chk("gvt_hold", gvt0, 101);
        chk("gvt_err_set", gvt_err0, 1);
        tick;
        @(negedge clk);
        chk("fin_pulse", rtn_vld0, 0);
        chk("fin_idle", busy0, 0);
        chk("fin_status_hold", rtn_status0, 0);
        chk("gvt_err_sticky", gvt_err0, 1);

        // Starvation: nothing queued, no cores, no receives
        tick;
        min_time_vld = 1'b0; end_time = 16'd1000; q_empty = 1'b1;
        for (int i = 0; i < 16; i++) exp_enq.push_back(mk(1'b0, 5'(i), 16'd0));
        exp_rtn.push_back(2'd2);
        start = 1'b1;
        tick;
        start = 1'b0;
        @(negedge clk);
        chk("start_clr_err", gvt_err0, 0);
        chk("start_clr_gvt", gvt0, 0);
        cyc = 0;
        while (!rtn_vld0 && cyc < 40) begin
            tick;
            @(negedge clk);
            cyc++;
        end
        chk("starve_cycle", cyc, 26);

        // Abort during INIT after 5 injections
        tick;
        for (int i = 0; i < 5; i++) exp_enq.push_back(mk(1'b0, 5'(i), 16'd0));
        exp_rtn.push_back(2'd1);
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_init_rtn", rtn_vld0, 1);
        chk("abort_init_enq", q_enq0, 0);

        // q_full for 3 cycles mid-INIT, then reset during RUNNING
        tick;
        min_time_vld = 1'b1; min_time = 16'd40; end_time = 16'd1000;
        for (int i = 0; i < 16; i++) exp_enq.push_back(mk(1'b0, 5'(i), 16'd0));
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int i = 0; i < 21; i++) begin
            q_full = (i >= 5) && (i <= 7);
            @(negedge clk);
            chk("stall_enq", q_enq0, !((i >= 5) && (i <= 7)) && (i < 19));
            tick;
        end
        q_full = 1'b0;
        chk("stall_count", exp_enq.size(), 0);
        @(negedge clk);
        chk("run_gvt_40", gvt0, 40);
        tick;
        reset = 1'b1; rcv_vld = 1'b1; rcv_msg = mk(1'b0, 5'd4, 16'd77);
        @(negedge clk);
        chk("rst_run_ack", rcv_ack0, 0);
        chk("rst_run_enq", q_enq0, 0);
        tick;
        @(negedge clk);
        chk("rst_run_busy", busy0, 0);
        chk("rst_run_gvt", gvt0, 0);
        reset = 1'b0; rcv_vld = 1'b0;
        tick;

        chk("enq_left", exp_enq.size(), 0);
        chk("rtn_left", exp_rtn.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
